// File: rtl/data_mem.sv
// data_mem: 128 x 32-bit word-addressed data memory for the MIPS MEM stage.
// Writes commit on the rising clock edge; reads are combinational and
// return zero whenever MemRead is low. A synchronous reset clears every word,
// which is why the array is kept in flip-flops rather than a block RAM
// (a block RAM cannot be cleared in a single cycle).
module data_mem #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              MemWrite,
   input  logic              MemRead,
   output logic [DATA_W-1:0] ReadData
);

   // Word storage; the address indexes it directly (no byte offset).
   logic [DATA_W-1:0] mem [DEPTH];

   // Whole-array clear on reset (reset wins over a same-cycle write),
   // otherwise a single-word write when MemWrite is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (MemWrite) begin
         mem[Address] <= WriteData;
      end
   end

   // Zero-latency read; shows pre-edge contents during a same-address write.
   always_comb begin
      ReadData = '0;
      if (MemRead) begin
         ReadData = mem[Address];
      end
   end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
module tb_data_mem;

   logic        clk;
   logic        rst;
   logic [6:0]  Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;

   int checks;
   int passed;
   logic [31:0] ref_mem [128];

   data_mem #(.DATA_W(32), .ADDR_W(7), .DEPTH(128)) dut (
      .clk       (clk),
      .rst       (rst),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past one rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
   endtask

   task automatic write_word(input logic [6:0] a, input logic [31:0] d);
      Address   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [6:0] a, input logic [31:0] expected);
      Address = a;
      MemRead = 1'b1;
      #1;
      check(tag, ReadData, expected);
   endtask

   initial begin
      checks    = 0;
      passed    = 0;
      rst       = 1'b1;
      Address   = '0;
      WriteData = '0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;

      // Reset held for two edges, then every address reads zero.
      tick();
      tick();
      rst = 1'b0;
      check("reset_readdata_memread0", ReadData, 32'h0);
      for (int a = 0; a < 128; a++) begin
         read_check($sformatf("reset_scan_%02h", a), 7'(a), 32'h0);
      end
      $display("reset scan done: 128 addresses");

      // Basic write held for 3 edges, then gated read.
      MemRead   = 1'b0;
      Address   = 7'h24;
      WriteData = 32'h12153524;
      MemWrite  = 1'b1;
      tick(); tick(); tick();
      MemWrite  = 1'b0;
      MemRead   = 1'b1;
      #1;
      check("basic_read", ReadData, 32'h12153524);
      MemRead = 1'b0;
      #1;
      check("basic_memread0", ReadData, 32'h0);
      $display("basic write/read at 0x24 done");

      // Boundary addresses.
      write_word(7'h00, 32'hDEADBEEF);
      write_word(7'h7F, 32'hCAFEF00D);
      read_check("bound_00", 7'h00, 32'hDEADBEEF);
      read_check("bound_7f", 7'h7F, 32'hCAFEF00D);
      read_check("bound_01", 7'h01, 32'h0);
      read_check("bound_7e", 7'h7E, 32'h0);
      $display("boundary addresses done");

      // Same-cycle read and write: old value before edge, new after.
      write_word(7'h10, 32'h11111111);
      Address   = 7'h10;
      MemRead   = 1'b1;
      WriteData = 32'h22222222;
      MemWrite  = 1'b1;
      #1;
      check("rw_same_before_edge", ReadData, 32'h11111111);
      tick();
      check("rw_same_after_edge", ReadData, 32'h22222222);
      MemWrite = 1'b0;
      $display("same-cycle read/write done");

      // Reset has priority over a simultaneous write.
      write_word(7'h05, 32'hA5A5A5A5);
      read_check("rstprio_pre", 7'h05, 32'hA5A5A5A5);
      rst       = 1'b1;
      MemWrite  = 1'b1;
      WriteData = 32'hFFFFFFFF;
      Address   = 7'h05;
      tick();
      rst      = 1'b0;
      MemWrite = 1'b0;
      read_check("rstprio_05", 7'h05, 32'h0);
      read_check("rstprio_24", 7'h24, 32'h0);
      read_check("rstprio_7f", 7'h7F, 32'h0);
      $display("reset priority done");

      // Model now all zero; seed a few words then toggle inputs with MemWrite=0.
      for (int a = 0; a < 128; a++) ref_mem[a] = 32'h0;
      write_word(7'h30, 32'h30303030); ref_mem[7'h30] = 32'h30303030;
      write_word(7'h31, 32'h0BADF00D); ref_mem[7'h31] = 32'h0BADF00D;
      for (int c = 0; c < 10; c++) begin
         Address   = 7'($urandom_range(0, 127));
         WriteData = $urandom;
         MemWrite  = 1'b0;
         tick();
      end
      read_check("wdis_30", 7'h30, 32'h30303030);
      read_check("wdis_31", 7'h31, 32'h0BADF00D);
      for (int a = 0; a < 128; a++) begin
         read_check($sformatf("wdis_scan_%02h", a), 7'(a), ref_mem[a]);
      end
      $display("write-disable sweep done");

      // 128 random writes against the reference array, then full read-back.
      for (int c = 0; c < 128; c++) begin
         logic [6:0]  ra;
         logic [31:0] rd;
         ra = 7'($urandom_range(0, 127));
         rd = $urandom;
         write_word(ra, rd);
         ref_mem[ra] = rd;
      end
      for (int a = 0; a < 128; a++) begin
         read_check($sformatf("rand_scan_%02h", a), 7'(a), ref_mem[a]);
      end
      MemRead = 1'b0;
      #1;
      check("final_memread0", ReadData, 32'h0);
      $display("random sweep done");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
